// File: rtl/deinterleaver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deinterleaver_pkg
// Description : Shared types for the two-lane deinterleaver datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package deinterleaver_pkg;

    localparam int CP_W = 16;

    typedef struct packed {
        logic signed [CP_W-1:0] re;
        logic signed [CP_W-1:0] im;
    } complex_product_t;

endpackage
`default_nettype wire

// File: rtl/deinterleaver_if.sv
`default_nettype none
// ============================================================================
// Module      : deinterleaver_if
// Description : Pair-stream input and aligned serial output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface deinterleaver_if;
    import deinterleaver_pkg::*;

    logic             in_valid;
    complex_product_t in_0;
    complex_product_t in_1;
    complex_product_t out_0;
    complex_product_t out_1;
    logic             out_valid;

    modport master (
        output in_valid, in_0, in_1,
        input  out_0, out_1, out_valid
    );

    modport slave (
        input  in_valid, in_0, in_1,
        output out_0, out_1, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/deinterleaver_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_buffer
// Description : 2 x N sample store; pair writes (k, k+N/2), serial reads.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_buffer #(
    parameter int  N = 8,
    parameter type T = logic [31:0]
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  swap,
    input  logic                  wr_en,
    input  logic [$clog2(N)-2:0]  wr_idx,
    input  T                      wr_lo,
    input  T                      wr_hi,
    input  logic                  rd_bank,
    input  logic [$clog2(N)-1:0]  rd_idx,
    output T                      rd_data,
    output logic                  wr_bank
);

    T     r_mem [2*N];
    logic r_wr_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
        end else if (swap) begin
            r_wr_bank <= ~r_wr_bank;
        end
    end

    // Lane 0 lands in the lower half of the bank, lane 1 in the upper half.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[{r_wr_bank, 1'b0, wr_idx}] <= wr_lo;
            r_mem[{r_wr_bank, 1'b1, wr_idx}] <= wr_hi;
        end
    end

    assign rd_data = r_mem[{rd_bank, rd_idx}];
    assign wr_bank = r_wr_bank;

endmodule
`default_nettype wire

// File: rtl/deinterleaver.sv
`default_nettype none
// ============================================================================
// Module      : deinterleaver
// Description : Rebuilds streams A and B from the folded two-lane pair format.
//               Optional sticky abort_flag port: DEINTERLEAVER_ABORT_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module deinterleaver
    import deinterleaver_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
`ifdef DEINTERLEAVER_ABORT_FLAG_EN
    output logic           abort_flag,
`endif
    deinterleaver_if.slave bus
);

    localparam int              AW     = $clog2(N);
    localparam int              HALF   = N / 2;
    localparam int              D      = HALF + 1;
    localparam logic [AW-1:0]   C_LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_phase;
    // Per-pair tag pipeline: valid, block position j and bank of the block.
    logic [D-1:0]     r_pv;
    logic [D-1:0]     r_pb;
    logic [AW-1:0]    r_pj [D];
    complex_product_t r_in0;
    complex_product_t r_in1;
    complex_product_t r_dly [HALF];
    logic             r_out_valid;
    complex_product_t r_out_0;
    complex_product_t r_out_1;

    logic             w_abort;
    logic             w_swap;
    logic             w_a_we;
    logic             w_wr_bank;
    logic             w_ov_nxt;
    logic             w_busy;
    logic [D-1:0]     w_kill;
    complex_product_t w_a_rd;

    assign w_abort = !bus.in_valid && (r_phase != '0);
    assign w_swap  = bus.in_valid && (r_phase == C_LAST);
    assign w_a_we  = bus.in_valid && !r_phase[AW-1];

    // A partial block owns the current write bank; drop its in-flight tags.
    always_comb begin
        w_kill = '0;
        for (int i = 0; i < D; i++) begin
            w_kill[i] = w_abort && (r_pb[i] == w_wr_bank);
        end
    end

    assign w_ov_nxt = r_pv[D-1] && !w_kill[D-1];
    assign w_busy   = |(r_pv & ~w_kill);

    pingpong_buffer #(
        .N (N),
        .T (complex_product_t)
    ) u_abuf (
        .clk     (clk),
        .reset   (reset),
        .swap    (w_swap),
        .wr_en   (w_a_we),
        .wr_idx  (r_phase[AW-2:0]),
        .wr_lo   (bus.in_0),
        .wr_hi   (bus.in_1),
        .rd_bank (r_pb[D-1]),
        .rd_idx  (r_pj[D-1]),
        .rd_data (w_a_rd),
        .wr_bank (w_wr_bank)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
            r_pv    <= '0;
            r_pb    <= '0;
            for (int i = 0; i < D; i++) begin
                r_pj[i] <= '0;
            end
        end else begin
            r_phase <= bus.in_valid ? r_phase + 1'b1 : '0;
            r_pv    <= {r_pv[D-2:0] & ~w_kill[D-2:0], bus.in_valid};
            r_pb    <= {r_pb[D-2:0], w_wr_bank};
            r_pj[0] <= r_phase;
            for (int i = 1; i < D; i++) begin
                r_pj[i] <= r_pj[i-1];
            end
        end
    end

    // B path runs free: lane 0 one stage, lane 1 through the half-block line.
    always_ff @(posedge clk) begin
        r_in0    <= bus.in_0;
        r_in1    <= bus.in_1;
        r_dly[0] <= r_in1;
        for (int i = 1; i < HALF; i++) begin
            r_dly[i] <= r_dly[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_0     <= '0;
            r_out_1     <= '0;
        end else begin
            r_out_valid <= w_ov_nxt;
            r_out_0     <= w_ov_nxt ? w_a_rd : '0;
            r_out_1     <= w_ov_nxt ? (r_pj[D-1][AW-1] ? r_dly[HALF-1] : r_in0) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) r_state <= S_FILL;
                end
                S_FILL: begin
                    if (w_ov_nxt)                         r_state <= S_STREAM;
                    else if (!bus.in_valid && !w_busy)    r_state <= S_IDLE;
                end
                S_STREAM: begin
                    if (!bus.in_valid) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!w_ov_nxt) begin
                        r_state <= (bus.in_valid || r_phase != '0) ? S_FILL : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DEINTERLEAVER_ABORT_FLAG_EN
    logic r_abort_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_abort_flag <= 1'b0;
        end else if (w_abort) begin
            r_abort_flag <= 1'b1;
        end
    end

    assign abort_flag = r_abort_flag;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_0     = r_out_0;
    assign bus.out_1     = r_out_1;

endmodule
`default_nettype wire

// File: tb/tb_deinterleaver.sv
`default_nettype none
// ============================================================================
// Module      : tb_deinterleaver
// Description : Randomised self-checking bench with a block-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deinterleaver;
    import deinterleaver_pkg::*;

    localparam int N    = 8;
    localparam int H    = N / 2;
    localparam int MAXE = 2048;

    logic clk;
    logic reset;
`ifdef DEINTERLEAVER_ABORT_FLAG_EN
    logic abort_flag;
    logic obs_af [MAXE];
`endif

    deinterleaver_if bus ();

    deinterleaver #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DEINTERLEAVER_ABORT_FLAG_EN
        .abort_flag (abort_flag),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic             exp_v   [MAXE];
    complex_product_t exp_0   [MAXE];
    complex_product_t exp_1   [MAXE];
    int               exp_blk [MAXE];
    logic             obs_v   [MAXE];
    complex_product_t obs_0   [MAXE];
    complex_product_t obs_1   [MAXE];

    int m_cnt   = 0;
    int m_start = 0;
    int m_blk   = 0;
    complex_product_t zero = '0;

    function automatic complex_product_t cp(input int v);
        complex_product_t r;
        r.re = 16'(v);
        r.im = 16'(-v);
        return r;
    endfunction

    function automatic complex_product_t rnd_cp();
        complex_product_t r;
        r.re = 16'($urandom);
        r.im = 16'($urandom);
        return r;
    endfunction

    task automatic clear_exp(input int t, input int blk);
        for (int e = t; e < t + 2*N + 2 && e < MAXE; e++) begin
            if (blk < 0 || exp_blk[e] == blk) begin
                exp_v[e] = 1'b0; exp_0[e] = '0; exp_1[e] = '0; exp_blk[e] = 0;
            end
        end
    endtask

    // Model: pair c of a block starting at edge s. For c<H it carries a[c] and
    // a[c+H]; otherwise b[c-H] and b[c]. Sample x[j] leaves on edge s+H+1+j.
    task automatic model_edge(input int t, input logic v, input complex_product_t d0,
                              input complex_product_t d1, input logic r);
        int c;
        if (r) begin
            clear_exp(t, -1);
            m_cnt = 0;
        end else if (!v) begin
            if (m_cnt != 0) clear_exp(t, m_blk);
            m_cnt = 0;
        end else begin
            if (m_cnt == 0) begin
                m_start = t;
                m_blk++;
            end
            c = m_cnt;
            if (c < H) begin
                exp_v[m_start+H+1+c] = 1'b1; exp_0[m_start+H+1+c] = d0; exp_blk[m_start+H+1+c] = m_blk;
                exp_v[m_start+N+1+c] = 1'b1; exp_0[m_start+N+1+c] = d1; exp_blk[m_start+N+1+c] = m_blk;
            end else begin
                exp_1[m_start+1+c]   = d0;
                exp_1[m_start+H+1+c] = d1;
            end
            m_cnt = (c + 1) % N;
        end
    endtask

    task automatic tick(input logic v, input complex_product_t d0,
                        input complex_product_t d1, input logic r);
        reset        = r;
        bus.in_valid = v;
        bus.in_0     = d0;
        bus.in_1     = d1;
        @(posedge clk);
        model_edge(cyc, v, d0, d1, r);
        @(negedge clk);
        obs_v[cyc] = bus.out_valid;
        obs_0[cyc] = bus.out_0;
        obs_1[cyc] = bus.out_1;
`ifdef DEINTERLEAVER_ABORT_FLAG_EN
        obs_af[cyc] = abort_flag;
`endif
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, zero, zero, 1'b0);
    endtask

    task automatic send_block(input int ab, input int bb);
        for (int c = 0; c < N; c++) begin
            if (c < H) tick(1'b1, cp(ab + c), cp(ab + c + H), 1'b0);
            else       tick(1'b1, cp(bb + c - H), cp(bb + c), 1'b0);
        end
    endtask

    task automatic test_reset();
        int e0 = cyc;
        repeat (3) tick(1'b0, zero, zero, 1'b1);
        idle(2);
        for (int e = e0 + 2; e < cyc; e++) begin
            checks++;
            if (obs_v[e] !== 1'b0 || obs_0[e] !== zero || obs_1[e] !== zero) begin
                errors++;
                $display("FAIL reset e=%0d got v=%b %h %h want 0 0 0", e, obs_v[e], obs_0[e], obs_1[e]);
            end
        end
`ifdef DEINTERLEAVER_ABORT_FLAG_EN
        checks++;
        if (obs_af[cyc-1] !== 1'b0) begin
            errors++; $display("FAIL reset_abort_flag got %b want 0", obs_af[cyc-1]);
        end
`endif
    endtask

    task automatic test_single_block();
        int e0 = cyc;
        send_block(1, 16);
        idle(2*N);
        for (int j = 0; j < N; j++) begin
            checks++;
            if (obs_v[e0+H+1+j] !== 1'b1 || obs_0[e0+H+1+j] !== cp(1 + j) || obs_1[e0+H+1+j] !== cp(16 + j)) begin
                errors++;
                $display("FAIL single j=%0d got v=%b %h %h want 1 %h %h", j, obs_v[e0+H+1+j],
                         obs_0[e0+H+1+j], obs_1[e0+H+1+j], cp(1 + j), cp(16 + j));
            end
        end
        checks++;
        if (obs_v[e0+H] !== 1'b0 || obs_v[e0+H+1+N] !== 1'b0 || obs_0[e0+H+1+N] !== zero) begin
            errors++;
            $display("FAIL single_edges got v_before=%b v_after=%b out0_after=%h want 0 0 0",
                     obs_v[e0+H], obs_v[e0+H+1+N], obs_0[e0+H+1+N]);
        end
        for (int e = e0; e < cyc; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e] || obs_0[e] !== exp_0[e] || obs_1[e] !== exp_1[e]) begin
                errors++;
                $display("FAIL single_model e=%0d got v=%b %h %h want %b %h %h", e, obs_v[e], obs_0[e],
                         obs_1[e], exp_v[e], exp_0[e], exp_1[e]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e0 = cyc;
        int nv = 0;
        send_block(8'h00, 8'h20);
        send_block(8'h40, 8'h60);
        send_block(8'h80, 8'hA0);
        idle(2*N);
        for (int e = e0 + H + 1; e < e0 + H + 1 + 3*N; e++) nv += (obs_v[e] === 1'b1) ? 1 : 0;
        checks++;
        if (nv !== 3*N) begin
            errors++; $display("FAIL b2b_contiguous got %0d valid want %0d", nv, 3*N);
        end
        for (int e = e0; e < cyc; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e] || obs_0[e] !== exp_0[e] || obs_1[e] !== exp_1[e]) begin
                errors++;
                $display("FAIL b2b_model e=%0d got v=%b %h %h want %b %h %h", e, obs_v[e], obs_0[e],
                         obs_1[e], exp_v[e], exp_0[e], exp_1[e]);
            end
        end
    endtask

    task automatic test_abort();
        int e0 = cyc;
        int nv = 0;
        send_block(8'h10, 8'h30);
        for (int c = 0; c < 3; c++) tick(1'b1, cp(8'h50 + c), cp(8'h54 + c), 1'b0);
        idle(2*N);
        for (int e = e0; e < cyc; e++) nv += (obs_v[e] === 1'b1) ? 1 : 0;
        checks++;
        if (nv !== N) begin
            errors++; $display("FAIL abort_count got %0d valid want %0d", nv, N);
        end
`ifdef DEINTERLEAVER_ABORT_FLAG_EN
        checks++;
        if (obs_af[cyc-1] !== 1'b1) begin
            errors++; $display("FAIL abort_flag got %b want 1", obs_af[cyc-1]);
        end
`endif
        for (int e = e0; e < cyc; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e] || obs_0[e] !== exp_0[e] || obs_1[e] !== exp_1[e]) begin
                errors++;
                $display("FAIL abort_model e=%0d got v=%b %h %h want %b %h %h", e, obs_v[e], obs_0[e],
                         obs_1[e], exp_v[e], exp_0[e], exp_1[e]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0 = cyc;
        int er;
        int e1;
        for (int c = 0; c < N - 1; c++) begin
            if (c < H) tick(1'b1, cp(8'h60 + c), cp(8'h60 + c + H), 1'b0);
            else       tick(1'b1, cp(8'h70 + c - H), cp(8'h70 + c), 1'b0);
        end
        er = cyc;
        tick(1'b1, cp(8'h77), cp(8'h7F), 1'b1);
        checks++;
        if (obs_v[er-1] !== 1'b1 || obs_v[er] !== 1'b0 || obs_0[er] !== zero || obs_1[er] !== zero) begin
            errors++;
            $display("FAIL reset_mid got v_pre=%b v=%b %h %h want 1 0 0 0", obs_v[er-1], obs_v[er],
                     obs_0[er], obs_1[er]);
        end
        e1 = cyc;
        send_block(8'h30, 8'h38);
        idle(2*N);
        checks++;
        if (obs_v[e1+H] !== 1'b0 || obs_v[e1+H+1] !== 1'b1 || obs_0[e1+H+1] !== cp(8'h30)) begin
            errors++;
            $display("FAIL reset_mid_latency got v4=%b v5=%b out0=%h want 0 1 %h", obs_v[e1+H],
                     obs_v[e1+H+1], obs_0[e1+H+1], cp(8'h30));
        end
`ifdef DEINTERLEAVER_ABORT_FLAG_EN
        checks++;
        if (obs_af[er] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_abort_flag got %b want 0", obs_af[er]);
        end
`endif
        for (int e = e0; e < cyc; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e] || obs_0[e] !== exp_0[e] || obs_1[e] !== exp_1[e]) begin
                errors++;
                $display("FAIL reset_mid_model e=%0d got v=%b %h %h want %b %h %h", e, obs_v[e], obs_0[e],
                         obs_1[e], exp_v[e], exp_0[e], exp_1[e]);
            end
        end
    endtask

    task automatic test_drain_restart();
        int e0 = cyc;
        send_block(8'h90, 8'hB0);
        idle(2);
        send_block(8'hC0, 8'hE0);
        idle(2*N);
        checks++;
        if (obs_v[e0+H+N] !== 1'b1 || obs_v[e0+H+N+1] !== 1'b0 || obs_v[e0+H+N+2] !== 1'b0
            || obs_v[e0+H+N+3] !== 1'b1 || obs_0[e0+H+N+3] !== cp(8'hC0)) begin
            errors++;
            $display("FAIL drain_gap got v=%b%b%b%b out0=%h want 1001 %h", obs_v[e0+H+N], obs_v[e0+H+N+1],
                     obs_v[e0+H+N+2], obs_v[e0+H+N+3], obs_0[e0+H+N+3], cp(8'hC0));
        end
        for (int e = e0; e < cyc; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e] || obs_0[e] !== exp_0[e] || obs_1[e] !== exp_1[e]) begin
                errors++;
                $display("FAIL drain_model e=%0d got v=%b %h %h want %b %h %h", e, obs_v[e], obs_0[e],
                         obs_1[e], exp_v[e], exp_0[e], exp_1[e]);
            end
        end
    endtask

    task automatic test_random();
        int e0 = cyc;
        int nblk = 0;
        int nv = 0;
        int r;
        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                for (int c = 0; c < N; c++) tick(1'b1, rnd_cp(), rnd_cp(), 1'b0);
                nblk++;
            end else if (r < 8) begin
                repeat ($urandom_range(1, H + 1)) tick(1'b1, rnd_cp(), rnd_cp(), 1'b0);
                idle($urandom_range(1, 2));
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(2*N);
        for (int e = e0; e < cyc; e++) nv += (obs_v[e] === 1'b1) ? 1 : 0;
        checks++;
        if (nv !== N * nblk) begin
            errors++; $display("FAIL random_count got %0d valid want %0d", nv, N * nblk);
        end
        for (int e = e0; e < cyc; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e] || obs_0[e] !== exp_0[e] || obs_1[e] !== exp_1[e]) begin
                errors++;
                $display("FAIL random_model e=%0d got v=%b %h %h want %b %h %h", e, obs_v[e], obs_0[e],
                         obs_1[e], exp_v[e], exp_0[e], exp_1[e]);
            end
        end
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_0     = '0;
        bus.in_1     = '0;
        for (int e = 0; e < MAXE; e++) begin
            exp_v[e] = 1'b0; exp_0[e] = '0; exp_1[e] = '0; exp_blk[e] = 0;
        end
        test_reset();
        test_single_block();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_drain_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
